// File: rtl/sump3_lb_master.sv
// Local-bus initiator for the SUMP3 ctrl/data register pair; SUMP3_LB_MASTER_STATS_EN adds read/timeout counters.
// Latency: strobe one cycle after command accept, one idle cycle between strobes.
// Backpressure: cmd_ready only when idle; a pending response stalls the next read until rsp_ready.
module sump3_lb_master #(
  parameter int rd_timeout = 255,
  parameter int len_bits   = 16
) (
  input  logic                clk_lb,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wr,
  input  logic                cmd_sel,
  input  logic [len_bits-1:0] cmd_len,
  input  logic [31:0]         cmd_wd,
  output logic                lb_cs_ctrl,
  output logic                lb_cs_data,
  output logic                lb_wr,
  output logic                lb_rd,
  output logic [31:0]         lb_wr_d,
  input  logic [31:0]         lb_rd_d,
  input  logic                lb_rd_rdy,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_rd_d,
  output logic                rsp_last,
  output logic                rsp_timeout,
  output logic [31:0]         stat_rd_cnt,
  output logic [15:0]         stat_to_cnt
);

  typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, RSP, GAP} state_t;

  localparam logic [15:0]         TO_LAST = 16'(rd_timeout - 1);
  localparam logic [len_bits-1:0] ONE     = len_bits'(1);

  state_t              state_q, state_d;
  logic                rst_done_q;
  logic                wr_q, sel_q;
  logic [len_bits-1:0] rem_q;
  logic [15:0]         timer_q;
  logic [31:0]         wr_d_q, rsp_d_q;
  logic                rsp_last_q, rsp_to_q;
  logic                accept, rd_phase, rd_hit, rd_expire, strobe;

  assign accept    = (state_q == IDLE) && rst_done_q && cmd_valid;
  assign rd_phase  = (state_q == RD) || (state_q == RD_WAIT);
  assign rd_hit    = rd_phase && lb_rd_rdy;
  // timer_q counts cycles already spent since the strobe, so the strobe cycle itself is cycle 1
  assign rd_expire = rd_phase && !lb_rd_rdy && (timer_q == TO_LAST);

  always_ff @(posedge clk_lb or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (accept) state_d = cmd_wr ? WR : RD;
      WR:          state_d = (rem_q == ONE) ? IDLE : GAP;
      RD, RD_WAIT: state_d = (rd_hit || rd_expire) ? RSP : RD_WAIT;
      RSP:         if (rsp_ready) state_d = (rem_q == '0) ? IDLE : GAP;
      GAP:         state_d = wr_q ? WR : RD;
      default:     state_d = IDLE;
    endcase
  end

  always_comb begin
    strobe     = (state_q == WR) || (state_q == RD);
    cmd_ready  = (state_q == IDLE) && rst_done_q;
    lb_wr      = (state_q == WR);
    lb_rd      = (state_q == RD);
    lb_cs_ctrl = strobe && !sel_q;
    lb_cs_data = strobe && sel_q;
    rsp_valid  = (state_q == RSP);
  end

  always_ff @(posedge clk_lb or negedge reset_n) begin
    if (!reset_n) begin
      rst_done_q <= 1'b0;
      wr_q       <= 1'b0;
      sel_q      <= 1'b0;
      rem_q      <= '0;
      timer_q    <= '0;
      wr_d_q     <= '0;
      rsp_d_q    <= '0;
      rsp_last_q <= 1'b0;
      rsp_to_q   <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      if (accept) begin
        wr_q  <= cmd_wr;
        sel_q <= cmd_sel;
        rem_q <= (cmd_len == '0) ? ONE : cmd_len;
        if (cmd_wr) wr_d_q <= cmd_wd;
      end
      if (state_q == WR) rem_q <= rem_q - ONE;
      if (state_d == RD)  timer_q <= '0;
      else if (rd_phase)  timer_q <= timer_q + 16'd1;
      if (rd_hit) begin
        rsp_d_q    <= lb_rd_d;
        rsp_to_q   <= 1'b0;
        rsp_last_q <= (rem_q == ONE);
        rem_q      <= rem_q - ONE;
      end else if (rd_expire) begin
        // abort drops whatever is left of the burst
        rsp_d_q    <= '0;
        rsp_to_q   <= 1'b1;
        rsp_last_q <= 1'b1;
        rem_q      <= '0;
      end
    end
  end

  assign lb_wr_d     = wr_d_q;
  assign rsp_rd_d    = rsp_d_q;
  assign rsp_last    = rsp_last_q;
  assign rsp_timeout = rsp_to_q;

`ifdef SUMP3_LB_MASTER_STATS_EN
  logic [31:0] rd_cnt_q;
  logic [15:0] to_cnt_q;

  always_ff @(posedge clk_lb or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt_q <= '0;
      to_cnt_q <= '0;
    end else begin
      if (rd_hit) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (rd_expire && (to_cnt_q != 16'hFFFF)) to_cnt_q <= to_cnt_q + 16'd1;
    end
  end

  assign stat_rd_cnt = rd_cnt_q;
  assign stat_to_cnt = to_cnt_q;
`else
  assign stat_rd_cnt = '0;
  assign stat_to_cnt = '0;
`endif

endmodule
